// File: rtl/alu_share_arb.sv
// Shares one ALU between two request ports with round-robin arbitration,
// one-entry response buffers and per-port {Z,V,N} flag registers.
module alu_share_arb #(
    parameter logic [2:0] FLAGS_RST  = 3'b000,
    parameter bit         FIRST_PORT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [3:0]  p0_opcode,
    input  logic [15:0] p0_a,
    input  logic [15:0] p0_b,
    output logic        p0_resp_valid,
    input  logic        p0_resp_ready,
    output logic [15:0] p0_result,
    output logic        p0_err,
    output logic [2:0]  p0_flags,
    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [3:0]  p1_opcode,
    input  logic [15:0] p1_a,
    input  logic [15:0] p1_b,
    output logic        p1_resp_valid,
    input  logic        p1_resp_ready,
    output logic [15:0] p1_result,
    output logic        p1_err,
    output logic [2:0]  p1_flags,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    input  logic [15:0] alu_result,
    input  logic [2:0]  alu_flags
);

    logic elig0, elig1;
    logic gnt0, gnt1;
    logic prio;
    logic illegal;
    logic [15:0] cap_result;

    // Only the selected flag bits are sampled, so X on unused bits is harmless.
    function automatic logic [2:0] next_flags(
        input logic [3:0] op,
        input logic [2:0] cur,
        input logic [2:0] af
    );
        logic [2:0] nf;
        nf = cur;
        case (op)
            4'b0000, 4'b0001: nf = af;
            4'b0010, 4'b0100,
            4'b0101, 4'b0110: nf = {af[2], cur[1:0]};
            default:          nf = cur;
        endcase
        return nf;
    endfunction

    assign elig0 = p0_req_valid & (~p0_resp_valid | p0_resp_ready);
    assign elig1 = p1_req_valid & (~p1_resp_valid | p1_resp_ready);

    // prio names the port that wins when both are eligible.
    assign gnt0 = elig0 & (~elig1 | ~prio);
    assign gnt1 = elig1 & (~elig0 | prio);

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    always_comb begin
        alu_opcode = 4'b1111;
        alu_in1    = 16'h0000;
        alu_in2    = 16'h0000;
        unique case (1'b1)
            gnt0: begin
                alu_opcode = p0_opcode;
                alu_in1    = p0_a;
                alu_in2    = p0_b;
            end
            gnt1: begin
                alu_opcode = p1_opcode;
                alu_in1    = p1_a;
                alu_in2    = p1_b;
            end
            default: ;
        endcase
    end

    assign illegal    = (alu_opcode >= 4'b1010);
    assign cap_result = illegal ? 16'hFFFF : alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= FIRST_PORT;
        end else if (gnt0) begin
            prio <= 1'b1;
        end else if (gnt1) begin
            prio <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_resp_valid <= 1'b0;
            p0_result     <= 16'h0000;
            p0_err        <= 1'b0;
            p0_flags      <= FLAGS_RST;
        end else if (gnt0) begin
            p0_resp_valid <= 1'b1;
            p0_result     <= cap_result;
            p0_err        <= illegal;
            p0_flags      <= next_flags(alu_opcode, p0_flags, alu_flags);
        end else if (p0_resp_ready) begin
            p0_resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_resp_valid <= 1'b0;
            p1_result     <= 16'h0000;
            p1_err        <= 1'b0;
            p1_flags      <= FLAGS_RST;
        end else if (gnt1) begin
            p1_resp_valid <= 1'b1;
            p1_result     <= cap_result;
            p1_err        <= illegal;
            p1_flags      <= next_flags(alu_opcode, p1_flags, alu_flags);
        end else if (p1_resp_ready) begin
            p1_resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU and a
// per-port response scoreboard.
module tb_alu_share_arb;

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        err;
        logic [2:0]  fl;
    } req_t;

    typedef struct packed {
        logic [15:0] res;
        logic        err;
        logic [2:0]  fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req_valid, p0_req_ready;
    logic [3:0]  p0_opcode;
    logic [15:0] p0_a, p0_b;
    logic        p0_resp_valid, p0_resp_ready;
    logic [15:0] p0_result;
    logic        p0_err;
    logic [2:0]  p0_flags;
    logic        p1_req_valid, p1_req_ready;
    logic [3:0]  p1_opcode;
    logic [15:0] p1_a, p1_b;
    logic        p1_resp_valid, p1_resp_ready;
    logic [15:0] p1_result;
    logic        p1_err;
    logic [2:0]  p1_flags;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_in1, alu_in2;
    logic [15:0] alu_result;
    logic [2:0]  alu_flags;

    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_opcode(p0_opcode), .p0_a(p0_a), .p0_b(p0_b),
        .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready),
        .p0_result(p0_result), .p0_err(p0_err), .p0_flags(p0_flags),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_opcode(p1_opcode), .p1_a(p1_a), .p1_b(p1_b),
        .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready),
        .p1_result(p1_result), .p1_err(p1_err), .p1_flags(p1_flags),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    // Saturating ADD/SUB; Z-only class reports V=N=1 to expose leakage.
    always_comb begin
        logic signed [16:0] s;
        logic v;
        s = 17'sd0;
        v = 1'b0;
        alu_result = 16'h0000;
        alu_flags  = 3'b000;
        case (alu_opcode)
            4'b0000, 4'b0001: begin
                if (alu_opcode == 4'b0000)
                    s = $signed({alu_in1[15], alu_in1}) + $signed({alu_in2[15], alu_in2});
                else
                    s = $signed({alu_in1[15], alu_in1}) - $signed({alu_in2[15], alu_in2});
                if (s > 17'sd32767) begin
                    alu_result = 16'h7FFF; v = 1'b1;
                end else if (s < -17'sd32768) begin
                    alu_result = 16'h8000; v = 1'b1;
                end else begin
                    alu_result = s[15:0];
                end
                alu_flags = {alu_result == 16'h0000, v, alu_result[15]};
            end
            4'b0010: begin
                alu_result = alu_in1 ^ alu_in2;
                alu_flags  = {alu_result == 16'h0000, 2'b11};
            end
            4'b0011: begin
                alu_result = {15'h0, ^alu_in1};
                alu_flags  = 3'bxxx;
            end
            4'b1000: begin
                alu_result = alu_in1 + alu_in2;
                alu_flags  = 3'bxxx;
            end
            default: begin
                alu_result = 16'h1234;
                alu_flags  = 3'b111;
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic req_t rq(input logic [3:0] op,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] res, input logic err,
                                input logic [2:0] fl);
        return '{v: 1'b1, op: op, a: a, b: b, res: res, err: err, fl: fl};
    endfunction

    localparam req_t NONE = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (p0_resp_valid && p0_resp_ready) begin
                if (q0.size() == 0) begin
                    chk("p0_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("p0_result", {16'h0, p0_result}, {16'h0, e.res});
                    chk("p0_err", {31'h0, p0_err}, {31'h0, e.err});
                    chk("p0_flags", {29'h0, p0_flags}, {29'h0, e.fl});
                end
            end
            if (p1_resp_valid && p1_resp_ready) begin
                if (q1.size() == 0) begin
                    chk("p1_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("p1_result", {16'h0, p1_result}, {16'h0, e.res});
                    chk("p1_err", {31'h0, p1_err}, {31'h0, e.err});
                    chk("p1_flags", {29'h0, p1_flags}, {29'h0, e.fl});
                end
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cyc(input req_t r0, input req_t r1,
                       input logic rr0, input logic rr1,
                       input logic er0, input logic er1);
        p0_req_valid  = r0.v;
        p0_opcode     = r0.op;
        p0_a          = r0.a;
        p0_b          = r0.b;
        p1_req_valid  = r1.v;
        p1_opcode     = r1.op;
        p1_a          = r1.a;
        p1_b          = r1.b;
        p0_resp_ready = rr0;
        p1_resp_ready = rr1;
        @(negedge clk);
        chk("p0_req_ready", {31'h0, p0_req_ready}, {31'h0, er0});
        chk("p1_req_ready", {31'h0, p1_req_ready}, {31'h0, er1});
        if (er0) begin
            q0.push_back('{res: r0.res, err: r0.err, fl: r0.fl});
            chk("alu_drive_p0", {alu_opcode, alu_in1, alu_in2[11:0]},
                {r0.op, r0.a, r0.b[11:0]});
        end else if (er1) begin
            q1.push_back('{res: r1.res, err: r1.err, fl: r1.fl});
            chk("alu_drive_p1", {alu_opcode, alu_in1, alu_in2[11:0]},
                {r1.op, r1.a, r1.b[11:0]});
        end else begin
            chk("alu_idle", {alu_opcode, alu_in1, alu_in2[11:0]},
                {4'hF, 16'h0, 12'h0});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_t s;
        s = rq(4'h1, 16'd5, 16'd3, 16'h0002, 1'b0, 3'b000);
        rst_n = 1'b0;
        p0_req_valid = 0; p0_opcode = 0; p0_a = 0; p0_b = 0;
        p1_req_valid = 0; p1_opcode = 0; p1_a = 0; p1_b = 0;
        p0_resp_ready = 0; p1_resp_ready = 0;
        #12;
        chk("rst_resp_valid", {30'h0, p0_resp_valid, p1_resp_valid}, 32'd0);
        chk("rst_result", {p0_result, p1_result}, 32'd0);
        chk("rst_err", {30'h0, p0_err, p1_err}, 32'd0);
        chk("rst_flags", {26'h0, p0_flags, p1_flags}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(rq(4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 0, 3'b010), NONE, 1, 1, 1, 0);
        cyc(rq(4'h2, 16'h00FF, 16'h00FF, 16'h0000, 0, 3'b110), NONE, 1, 1, 1, 0);
        cyc(NONE, rq(4'h3, 16'h0007, 16'h0000, 16'h0001, 0, 3'b000), 1, 1, 0, 1);
        chk("p0_flags_zonly", {29'h0, p0_flags}, 32'd6);
        chk("p1_flags_isolated", {29'h0, p1_flags}, 32'd0);

        cyc(s, s, 1, 1, 1, 0);
        cyc(s, s, 1, 1, 0, 1);
        cyc(s, s, 1, 1, 1, 0);
        cyc(s, s, 1, 1, 0, 1);
        cyc(NONE, NONE, 1, 1, 0, 0);

        cyc(rq(4'h0, 16'd1, 16'd2, 16'h0003, 0, 3'b000), NONE, 0, 1, 1, 0);
        cyc(rq(4'h0, 16'd4, 16'd4, 16'h0008, 0, 3'b000), s, 0, 1, 0, 1);
        chk("p0_hold_result", {16'h0, p0_result}, 32'h0003);
        cyc(rq(4'h0, 16'd4, 16'd4, 16'h0008, 0, 3'b000), s, 0, 1, 0, 1);
        chk("p0_hold_valid", {31'h0, p0_resp_valid}, 32'd1);
        chk("p0_hold_result2", {16'h0, p0_result}, 32'h0003);
        cyc(rq(4'h0, 16'd4, 16'd4, 16'h0008, 0, 3'b000), NONE, 1, 1, 1, 0);
        cyc(NONE, NONE, 1, 1, 0, 0);

        cyc(NONE, rq(4'h0, 16'h8000, 16'hFFFF, 16'h8000, 0, 3'b011), 1, 1, 0, 1);
        cyc(NONE, rq(4'hC, 16'h0001, 16'h0001, 16'hFFFF, 1, 3'b011), 1, 1, 0, 1);
        cyc(NONE, rq(4'h8, 16'h0010, 16'h0004, 16'h0014, 0, 3'b011), 1, 1, 0, 1);
        cyc(NONE, NONE, 1, 1, 0, 0);

        cyc(NONE, rq(4'h8, 16'h0001, 16'h0001, 16'h0002, 0, 3'b011), 1, 0, 0, 1);
        cyc(rq(4'h0, 16'h0001, 16'h0001, 16'h0002, 0, 3'b000), NONE, 0, 0, 1, 0);
        cyc(NONE, NONE, 0, 0, 0, 0);
        chk("pre_rst_valid", {30'h0, p0_resp_valid, p1_resp_valid}, 32'd3);
        chk("pre_rst_p1_flags", {29'h0, p1_flags}, 32'd3);
        #3;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("mid_rst_valid", {30'h0, p0_resp_valid, p1_resp_valid}, 32'd0);
        chk("mid_rst_flags", {26'h0, p0_flags, p1_flags}, 32'd0);
        chk("mid_rst_result", {p0_result, p1_result}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(rq(4'h0, 16'd1, 16'd2, 16'h0003, 0, 3'b000),
            rq(4'h0, 16'd1, 16'd2, 16'h0003, 0, 3'b000), 1, 1, 1, 0);
        cyc(rq(4'h0, 16'd1, 16'd2, 16'h0003, 0, 3'b000),
            rq(4'h0, 16'd1, 16'd2, 16'h0003, 0, 3'b000), 1, 1, 0, 1);
        cyc(NONE, NONE, 1, 1, 0, 0);
        cyc(NONE, NONE, 1, 1, 0, 0);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
